// File: rtl/store_data_narrow_if.sv
// Store-path handshake bundle between EX and MEM around the narrowing buffer.
// ovf__o exists only when STORE_RANGE_CHK_EN is defined.
interface store_data_narrow_if #(
    parameter int WIDTH = 32
);
    localparam int BYTES = WIDTH / 8;

    logic               flush__i;
    logic               valid__i;
    logic               ready__o;
    logic [WIDTH-1:0]   data__i;
    logic [1:0]         size__i;
    logic [1:0]         addr__i;
    logic               valid__o;
    logic               ready__i;
    logic [WIDTH-1:0]   wdata__o;
    logic [BYTES-1:0]   be__o;
    logic               err__o;
`ifdef STORE_RANGE_CHK_EN
    logic               ovf__o;
`endif

    modport slave (
        input  flush__i, valid__i, data__i, size__i, addr__i, ready__i,
        output ready__o, valid__o, wdata__o, be__o, err__o
`ifdef STORE_RANGE_CHK_EN
        , output ovf__o
`endif
    );

    modport master (
        output flush__i, valid__i, data__i, size__i, addr__i, ready__i,
        input  ready__o, valid__o, wdata__o, be__o, err__o
`ifdef STORE_RANGE_CHK_EN
        , input ovf__o
`endif
    );
endinterface

// File: rtl/store_data_narrow.sv
// Store data narrowing/lane replication with byte enables, behind a small valid/ready buffer.
// Optional STORE_RANGE_CHK_EN adds a per-entry ovf flag (narrowed value does not sign-extend back).
module store_data_narrow #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic              clk__i,
    input  logic              rst_n__i,
    store_data_narrow_if.slave bus
);
    localparam int BYTES = WIDTH / 8;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef struct packed {
        logic [WIDTH-1:0] wdata;
        logic [BYTES-1:0] be;
        logic             err;
`ifdef STORE_RANGE_CHK_EN
        logic             ovf;
`endif
    } entry_t;

    entry_t           entries_q [DEPTH];
    entry_t           entries_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q, ready_d;
    entry_t           fmt;
    entry_t           head;
    logic             push;
    logic             pop;

    // Formatting happens at push so the stored entry is exactly what MEM sees.
    always_comb begin
        fmt = '0;
        unique case (bus.size__i)
            2'b00: begin
                fmt.wdata = {BYTES{bus.data__i[7:0]}};
                fmt.be    = BYTES'(1) << bus.addr__i;
`ifdef STORE_RANGE_CHK_EN
                fmt.ovf   = bus.data__i[WIDTH-1:7] != {(WIDTH-7){bus.data__i[7]}};
`endif
            end
            2'b01: begin
                fmt.wdata = {(BYTES/2){bus.data__i[15:0]}};
                if (bus.addr__i[0]) begin
                    fmt.err = 1'b1;
                end else begin
                    fmt.be  = BYTES'(3) << bus.addr__i;
                end
`ifdef STORE_RANGE_CHK_EN
                fmt.ovf   = bus.data__i[WIDTH-1:15] != {(WIDTH-15){bus.data__i[15]}};
`endif
            end
            2'b10: begin
                fmt.wdata = bus.data__i;
                if (bus.addr__i != 2'b00) begin
                    fmt.err = 1'b1;
                end else begin
                    fmt.be  = '1;
                end
            end
            default: begin
                fmt.wdata = bus.data__i;
                fmt.err   = 1'b1;
            end
        endcase
    end

    always_comb begin
        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        push      = bus.valid__i && ready_q && !bus.flush__i;
        pop       = (count_q != '0) && bus.ready__i && !bus.flush__i;

        if (bus.flush__i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                entries_d[wr_ptr_q] = fmt;
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end

        // Registered so ready__o never depends combinationally on ready__i.
        ready_d = count_d < DEPTH_C;
    end

    always_ff @(posedge clk__i or negedge rst_n__i) begin
        if (!rst_n__i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            entries_q <= entries_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
        end
    end

    assign head         = entries_q[rd_ptr_q];
    assign bus.ready__o = ready_q;
    assign bus.valid__o = (count_q != '0);
    assign bus.wdata__o = bus.valid__o ? head.wdata : '0;
    assign bus.be__o    = bus.valid__o ? head.be    : '0;
    assign bus.err__o   = bus.valid__o ? head.err   : 1'b0;
`ifdef STORE_RANGE_CHK_EN
    assign bus.ovf__o   = bus.valid__o ? head.ovf   : 1'b0;
`endif
endmodule
